sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'hFACECAFE, system ID value required at word 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h511B4A8E, generation timestamp required at word 1.
REQ-003 SHALL have parameter READ_LATENCY, default 0, legal range 0..3, cycles from accepted read to valid readdata.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, legal range 1..65535, maximum cycles per word transaction.
REQ-005 SHALL have parameter AUTO_START, default 1; when 1, a check starts automatically after reset.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: pulse that requests a check.
REQ-009 SHALL have port avm_address, output, 1 bit: word select toward the sysid slave (0 = ID, 1 = timestamp).
REQ-010 SHALL have port avm_read, output, 1 bit: read request.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: slave stall; tie low for sysid.
REQ-012 SHALL have port avm_readdata, input, 32 bits: slave read data.
REQ-013 SHALL have port busy, output, 1 bit: high while a check is in progress.
REQ-014 SHALL have port done, output, 1 bit: sticky flag, set when a check completes.
REQ-015 SHALL have ports id_ok and ts_ok, outputs, 1 bit each: comparison results, valid while done=1.
REQ-016 SHALL have port timeout, output, 1 bit: sticky flag, set when a transaction exceeds TIMEOUT_CYCLES.
REQ-017 SHALL have ports id_value and ts_value, outputs, 32 bits each: captured words.

Function
REQ-018 SHALL implement FSM states IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS and FIN.
REQ-019 SHALL move IDLE->REQ_ID on start=1, or on the first cycle after reset release when AUTO_START=1.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL, in FIN, move to REQ_ID on start=1; a restart SHALL clear done, id_ok, ts_ok and timeout on the cycle it is taken.
REQ-022 SHALL assert avm_read=1 in REQ_ID (avm_address=0) and in REQ_TS (avm_address=1), holding address and read stable while avm_waitrequest=1.
REQ-023 SHALL define an accepted read as avm_read=1 and avm_waitrequest=0 in the same cycle.
REQ-024 SHALL, when READ_LATENCY=0, capture avm_readdata in the acceptance cycle and skip the LAT state.
REQ-025 SHALL, when READ_LATENCY=N>0, deassert avm_read after acceptance, wait in the LAT state, and capture avm_readdata exactly N cycles after acceptance.
REQ-026 SHALL advance REQ_ID/LAT_ID->REQ_TS on ID capture, and REQ_TS/LAT_TS->FIN on timestamp capture.
REQ-027 SHALL, in FIN, set done=1, id_ok=(id_value==EXPECTED_ID) and ts_ok=(ts_value==EXPECTED_TS), registered one cycle after the timestamp capture.
REQ-028 SHALL clear a 16-bit per-transaction counter on entry to each REQ state.
REQ-029 SHALL increment that counter each cycle in REQ or LAT.
REQ-030 SHALL, if the counter reaches TIMEOUT_CYCLES before capture, deassert avm_read, set timeout=1, set done=1, set id_ok=ts_ok=0, and go to FIN.
REQ-031 SHALL give capture precedence over timeout when both occur in the same cycle.
REQ-032 SHALL drive busy=1 in every state except IDLE and FIN.
REQ-033 SHALL keep avm_read=0 in IDLE, LAT_* and FIN.

Reset
REQ-034 SHALL, with reset=1 on a rising edge, force state to IDLE and drive avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0 and counter=0.
REQ-035 SHALL give reset priority over all other inputs, including mid-transaction; a check restarts only per REQ-019.

Verification
REQ-036 SHALL pass this check: AUTO_START=1, latency 0, waitrequest=0, slave returns FACECAFE/511B4A8E -> read at address 0 then address 1 on consecutive cycles; done=1, id_ok=1, ts_ok=1 on cycle 3 after reset release.
REQ-037 SHALL pass this check: word 1 returns 511B4A8F -> id_ok=1, ts_ok=0, ts_value=511B4A8F, timeout=0.
REQ-038 SHALL pass this check: READ_LATENCY=2, waitrequest high for 3 cycles on each word -> address and read held stable during the stall; data captured exactly 2 cycles after each acceptance; pass result.
REQ-039 SHALL pass this check: TIMEOUT_CYCLES=8, waitrequest stuck high -> avm_read drops, timeout=1, done=1, id_ok=0, ts_ok=0, busy=0 after 8 cycles.
REQ-040 SHALL pass this check: reset asserted in LAT_TS, then AUTO_START=0 with start pulsed in FIN -> all outputs return to reset values; start pulses during busy are ignored; a restart clears done on the cycle it is taken.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: reads the ID and timestamp words from an Avalon-MM sysid
// slave, compares them against the expected build values and reports the
// result through sticky done/ok/timeout flags.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hFACECAFE,
    parameter logic [31:0] EXPECTED_TS    = 32'h511B4A8E,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [1:0]  LAT_N     = 2'(READ_LATENCY);
    localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        LAT_ID,
        REQ_TS,
        LAT_TS,
        FIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [1:0]  lat_count;
    logic        auto_pending;
    logic        id_match;
    logic        accepted;
    logic        capture_id;
    logic        capture_ts;
    logic        tmo_hit;
    logic        limit_reached;

    // Next-state, bus outputs and capture/timeout strobes; a capture always
    // wins over a timeout landing in the same cycle.
    always_comb begin
        state_next    = state;
        avm_read      = 1'b0;
        avm_address   = 1'b0;
        busy          = 1'b0;
        accepted      = 1'b0;
        capture_id    = 1'b0;
        capture_ts    = 1'b0;
        tmo_hit       = 1'b0;
        limit_reached = ({1'b0, count} + 17'd1) >= TMO_LIMIT;
        case (state)
            IDLE: begin
                if (start || auto_pending) state_next = REQ_ID;
            end
            REQ_ID: begin
                avm_read = 1'b1;
                busy     = 1'b1;
                accepted = !avm_waitrequest;
                if (accepted && (LAT_N == 2'd0)) begin
                    capture_id = 1'b1;
                    state_next = REQ_TS;
                end else if (limit_reached) begin
                    tmo_hit    = 1'b1;
                    state_next = FIN;
                end else if (accepted) begin
                    state_next = LAT_ID;
                end
            end
            LAT_ID: begin
                busy = 1'b1;
                if (lat_count == LAT_N) begin
                    capture_id = 1'b1;
                    state_next = REQ_TS;
                end else if (limit_reached) begin
                    tmo_hit    = 1'b1;
                    state_next = FIN;
                end
            end
            REQ_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                busy        = 1'b1;
                accepted    = !avm_waitrequest;
                if (accepted && (LAT_N == 2'd0)) begin
                    capture_ts = 1'b1;
                    state_next = FIN;
                end else if (limit_reached) begin
                    tmo_hit    = 1'b1;
                    state_next = FIN;
                end else if (accepted) begin
                    state_next = LAT_TS;
                end
            end
            LAT_TS: begin
                busy = 1'b1;
                if (lat_count == LAT_N) begin
                    capture_ts = 1'b1;
                    state_next = FIN;
                end else if (limit_reached) begin
                    tmo_hit    = 1'b1;
                    state_next = FIN;
                end
            end
            FIN: begin
                if (start) state_next = REQ_ID;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Arms the automatic check so it fires on the first cycle after reset.
    always_ff @(posedge clock) begin
        if (reset) auto_pending <= AUTO_START;
        else       auto_pending <= 1'b0;
    end

    // Per-transaction timeout counter and read-latency counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= 16'd0;
            lat_count <= 2'd0;
        end else begin
            if ((state_next == REQ_ID && state != REQ_ID) ||
                (state_next == REQ_TS && state != REQ_TS))
                count <= 16'd0;
            else if (busy)
                count <= count + 16'd1;
            if (accepted)
                lat_count <= 2'd1;
            else if (state == LAT_ID || state == LAT_TS)
                lat_count <= lat_count + 2'd1;
        end
    end

    // Captured words and sticky result flags; a restart from FIN clears the flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
            id_match <= 1'b0;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (state == FIN && start) begin
                done    <= 1'b0;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (capture_id) begin
                id_value <= avm_readdata;
                id_match <= (avm_readdata == EXPECTED_ID);
            end
            if (capture_ts) begin
                ts_value <= avm_readdata;
                done     <= 1'b1;
                id_ok    <= id_match;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
                done    <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: one default instance (auto start,
// zero latency) and one with latency 2, timeout 8 and manual start.
module tb_sysid_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cmp_count  = 0;
    int fail_count = 0;

    // Instance A: defaults
    logic        reset_a = 1'b1;
    logic        start_a = 1'b0;
    logic        addr_a, read_a, busy_a, done_a, id_ok_a, ts_ok_a, timeout_a;
    logic [31:0] rdata_a, id_value_a, ts_value_a;
    logic [31:0] ts_word_a = 32'h511B4A8E;

    assign rdata_a = addr_a ? ts_word_a : 32'hFACECAFE;

    sysid_checker dut_a (
        .clock(clock), .reset(reset_a), .start(start_a),
        .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(1'b0),
        .avm_readdata(rdata_a), .busy(busy_a), .done(done_a),
        .id_ok(id_ok_a), .ts_ok(ts_ok_a), .timeout(timeout_a),
        .id_value(id_value_a), .ts_value(ts_value_a)
    );

    // Instance B: latency 2, timeout 8, manual start
    logic        reset_b = 1'b1;
    logic        start_b = 1'b0;
    logic        stuck_b = 1'b0;
    logic        addr_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, timeout_b;
    logic        wait_b;
    logic [31:0] rdata_b, id_value_b, ts_value_b;
    int          stall_cnt = 0;
    logic        v1 = 1'b0, v2 = 1'b0, a1 = 1'b0, a2 = 1'b0;

    assign wait_b  = stuck_b || (read_b && stall_cnt < 3);
    assign rdata_b = v2 ? (a2 ? 32'h511B4A8E : 32'hFACECAFE) : 32'hDEADBEEF;

    // Slave model: stalls 3 cycles per read, returns data exactly 2 cycles after acceptance
    always @(posedge clock) begin
        if (!read_b) stall_cnt <= 0;
        else if (stall_cnt < 3) stall_cnt <= stall_cnt + 1;
        v1 <= read_b && !wait_b;
        a1 <= addr_b;
        v2 <= v1;
        a2 <= a1;
    end

    sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b),
        .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wait_b),
        .avm_readdata(rdata_b), .busy(busy_b), .done(done_b),
        .id_ok(id_ok_b), .ts_ok(ts_ok_b), .timeout(timeout_b),
        .id_value(id_value_b), .ts_value(ts_value_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmp_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Pulses start on the selected instance for one rising edge
    task automatic applyStimulus(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        waitCycles(3);
        checkOutput("a_rst_busy", 32'(busy_a), 32'd0);
        checkOutput("a_rst_read", 32'(read_a), 32'd0);
        checkOutput("a_rst_done", 32'(done_a), 32'd0);
        checkOutput("a_rst_idval", id_value_a, 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Auto start: ID read, TS read, result on the third cycle
        waitCycles(1);
        checkOutput("a_c1_read", 32'(read_a), 32'd1);
        checkOutput("a_c1_addr", 32'(addr_a), 32'd0);
        waitCycles(1);
        checkOutput("a_c2_read", 32'(read_a), 32'd1);
        checkOutput("a_c2_addr", 32'(addr_a), 32'd1);
        checkOutput("a_c2_done", 32'(done_a), 32'd0);
        waitCycles(1);
        checkOutput("a_c3_done", 32'(done_a), 32'd1);
        checkOutput("a_c3_idok", 32'(id_ok_a), 32'd1);
        checkOutput("a_c3_tsok", 32'(ts_ok_a), 32'd1);
        checkOutput("a_c3_busy", 32'(busy_a), 32'd0);
        checkOutput("a_c3_idval", id_value_a, 32'hFACECAFE);
        checkOutput("b_idle_busy", 32'(busy_b), 32'd0);

        // Wrong timestamp on restart
        ts_word_a = 32'h511B4A8F;
        applyStimulus(0);
        checkOutput("a_rs_done", 32'(done_a), 32'd0);
        waitCycles(2);
        checkOutput("a_bad_done", 32'(done_a), 32'd1);
        checkOutput("a_bad_idok", 32'(id_ok_a), 32'd1);
        checkOutput("a_bad_tsok", 32'(ts_ok_a), 32'd0);
        checkOutput("a_bad_tsval", ts_value_a, 32'h511B4A8F);
        checkOutput("a_bad_tmo", 32'(timeout_a), 32'd0);

        // Latency 2 with 3-cycle stalls per word
        applyStimulus(1);
        checkOutput("b_c1_read", 32'(read_b), 32'd1);
        checkOutput("b_c1_busy", 32'(busy_b), 32'd1);
        waitCycles(2);
        checkOutput("b_c3_read", 32'(read_b), 32'd1);
        checkOutput("b_c3_addr", 32'(addr_b), 32'd0);
        waitCycles(1);
        checkOutput("b_c4_read", 32'(read_b), 32'd1);
        waitCycles(1);
        checkOutput("b_c5_read", 32'(read_b), 32'd0);
        waitCycles(1);
        checkOutput("b_c6_busy", 32'(busy_b), 32'd1);
        waitCycles(1);
        checkOutput("b_c7_addr", 32'(addr_b), 32'd1);
        start_b = 1'b1;
        waitCycles(1);
        start_b = 1'b0;
        waitCycles(1);
        checkOutput("b_c9_read", 32'(read_b), 32'd1);
        checkOutput("b_c9_addr", 32'(addr_b), 32'd1);
        waitCycles(2);
        checkOutput("b_c11_read", 32'(read_b), 32'd0);
        waitCycles(1);
        checkOutput("b_c12_done", 32'(done_b), 32'd0);
        waitCycles(1);
        checkOutput("b_c13_done", 32'(done_b), 32'd1);
        checkOutput("b_c13_idok", 32'(id_ok_b), 32'd1);
        checkOutput("b_c13_tsok", 32'(ts_ok_b), 32'd1);
        checkOutput("b_c13_idval", id_value_b, 32'hFACECAFE);
        checkOutput("b_c13_tsval", ts_value_b, 32'h511B4A8E);
        checkOutput("b_c13_busy", 32'(busy_b), 32'd0);

        // Waitrequest stuck: timeout after 8 cycles
        stuck_b = 1'b1;
        applyStimulus(1);
        checkOutput("b_tr_done", 32'(done_b), 32'd0);
        checkOutput("b_tr_idok", 32'(id_ok_b), 32'd0);
        waitCycles(7);
        checkOutput("b_t8_read", 32'(read_b), 32'd1);
        checkOutput("b_t8_tmo", 32'(timeout_b), 32'd0);
        waitCycles(1);
        checkOutput("b_t9_tmo", 32'(timeout_b), 32'd1);
        checkOutput("b_t9_done", 32'(done_b), 32'd1);
        checkOutput("b_t9_idok", 32'(id_ok_b), 32'd0);
        checkOutput("b_t9_tsok", 32'(ts_ok_b), 32'd0);
        checkOutput("b_t9_busy", 32'(busy_b), 32'd0);
        checkOutput("b_t9_read", 32'(read_b), 32'd0);

        // Restart clears timeout, then reset while in LAT_TS
        stuck_b = 1'b0;
        applyStimulus(1);
        checkOutput("b_rs_tmo", 32'(timeout_b), 32'd0);
        checkOutput("b_rs_done", 32'(done_b), 32'd0);
        waitCycles(10);
        checkOutput("b_lat_read", 32'(read_b), 32'd0);
        checkOutput("b_lat_busy", 32'(busy_b), 32'd1);
        reset_b = 1'b1;
        waitCycles(1);
        reset_b = 1'b0;
        checkOutput("b_rr_busy", 32'(busy_b), 32'd0);
        checkOutput("b_rr_idval", id_value_b, 32'd0);
        checkOutput("b_rr_tsval", ts_value_b, 32'd0);
        checkOutput("b_rr_done", 32'(done_b), 32'd0);
        waitCycles(3);
        checkOutput("b_idle_read", 32'(read_b), 32'd0);
        checkOutput("b_idle_busy2", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
